// File: rtl/spi_cfg_ctrl_if.sv
// Connects the SPI pins to the configuration controller and carries its register and update outputs.
// The master side drives the pins, and the slave side is the controller.
interface spi_cfg_ctrl_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       cfg_update;

  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, cfg_update
  );

  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle, cfg_update
  );
endinterface

// File: rtl/spi_cfg_ctrl.sv
// SPI mode-0 slave that accepts 16-bit write frames and commits them into the PWM config registers.
// A commit lands SYNC_STAGES+1 clk edges after ncs rises. There is no backpressure, and bad frames are dropped.
module spi_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input logic           clk,
  input logic           rst_n,
  spi_cfg_ctrl_if.slave bus
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;

  state_t      state_q;
  logic [15:0] shift_q;
  logic [4:0]  cnt_q;
  logic [7:0]  regs_q [NUM_REGS];
  logic        cfg_update_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;
  logic commit_ok;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign commit_ok = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] < NUM_REGS_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      cfg_update_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      cfg_update_q <= 1'b0;
      case (state_q)
        // Wait out any frame already in flight when reset was released.
        WAIT_IDLE: if (ncs_s) state_q <= IDLE;
        IDLE: begin
          if (ncs_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // An ncs rise takes precedence over a coincident sclk rise.
          if (ncs_rise) begin
            if (commit_ok) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (shift_q[14:8] == 7'(i)) regs_q[i] <= shift_q[7:0];
              end
              cfg_update_q <= 1'b1;
            end
            state_q <= IDLE;
          end else if (sclk_rise) begin
            shift_q <= {shift_q[14:0], copi_s};
            if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.en_reg_out_7_0  = regs_q[0];
  assign bus.en_reg_out_15_8 = regs_q[1];
  assign bus.en_reg_pwm_7_0  = regs_q[2];
  assign bus.en_reg_pwm_15_8 = regs_q[3];
  assign bus.pwm_duty_cycle  = regs_q[4];
  assign bus.cfg_update      = cfg_update_q;

endmodule
